// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for 24-bit stereo samples in a 64-bit-clock frame.
// BCLK and LRCK are derived from clk_i by an even divider. A one-entry holding
// buffer decouples the upstream handshake from the frame-rate shift registers.
// A frame that starts with an empty buffer plays silence and records an underrun.
module i2s_tx #(
   parameter int MCLK_DIV = 8
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        sample_valid_i,
   input  logic [23:0] sample_left_i,
   input  logic [23:0] sample_right_i,
   output logic        sample_ready_o,
   input  logic        mute_i,
   output logic        bclk_o,
   output logic        lrck_o,
   output logic        sdata_o,
   output logic        underrun_o,
   output logic [15:0] underrun_count_o
);

   localparam int DW = $clog2(MCLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV / 2);

   logic [DW-1:0] div_cnt_reg;
   logic [DW-1:0] div_cnt_next;
   logic [5:0]    bit_cnt_reg;
   logic [5:0]    bit_cnt_next;
   logic          bclk_reg;
   logic          lrck_reg;
   logic          sdata_reg;
   logic          buf_empty_reg;
   logic [23:0]   buf_left_reg;
   logic [23:0]   buf_right_reg;
   logic [23:0]   shift_left_reg;
   logic [23:0]   shift_right_reg;
   logic          underrun_reg;
   logic [15:0]   underrun_count_reg;

   logic          fall_event;
   logic          frame_start;
   logic          transfer;
   logic          left_slot;
   logic          right_slot;

   // Next-state values and event decode shared by the sequential blocks
   always_comb begin
      div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
      bit_cnt_next = bit_cnt_reg + 6'd1;
      fall_event   = (div_cnt_reg == DIV_LAST);
      // Frame start is the fall event that carries bit_cnt from 63 to 0
      frame_start  = fall_event && (bit_cnt_reg == 6'd63);
      transfer     = sample_valid_i && buf_empty_reg;
      // One-bit I2S delay: data occupies bits 1..24 and 33..56 of the frame
      left_slot    = (bit_cnt_next >= 6'd1)  && (bit_cnt_next <= 6'd24);
      right_slot   = (bit_cnt_next >= 6'd33) && (bit_cnt_next <= 6'd56);
   end

   // Clock divider; BCLK rises mid-period and falls at the wrap
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         div_cnt_reg <= '0;
         bclk_reg    <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         if (div_cnt_next == DIV_HALF) begin
            bclk_reg <= 1'b1;
         end else if (div_cnt_next == '0) begin
            bclk_reg <= 1'b0;
         end
      end
   end

   // Bit counter, word select, shift registers and serial data, all on fall events
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bit_cnt_reg     <= 6'd63;
         lrck_reg        <= 1'b0;
         sdata_reg       <= 1'b0;
         shift_left_reg  <= '0;
         shift_right_reg <= '0;
      end else if (fall_event) begin
         bit_cnt_reg <= bit_cnt_next;
         lrck_reg    <= bit_cnt_next[5];
         if (frame_start) begin
            // Mute is only looked at here; the buffer is consumed either way
            if (!buf_empty_reg && !mute_i) begin
               shift_left_reg  <= buf_left_reg;
               shift_right_reg <= buf_right_reg;
            end else begin
               shift_left_reg  <= '0;
               shift_right_reg <= '0;
            end
            sdata_reg <= 1'b0;
         end else if (left_slot) begin
            sdata_reg      <= shift_left_reg[23];
            shift_left_reg <= {shift_left_reg[22:0], 1'b0};
         end else if (right_slot) begin
            sdata_reg       <= shift_right_reg[23];
            shift_right_reg <= {shift_right_reg[22:0], 1'b0};
         end else begin
            sdata_reg <= 1'b0;
         end
      end
   end

   // Holding buffer: filled by a handshake, emptied by the frame-start load.
   // A transfer on the frame-start edge only happens when empty, so it wins.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         buf_empty_reg <= 1'b1;
         buf_left_reg  <= '0;
         buf_right_reg <= '0;
      end else if (transfer) begin
         buf_empty_reg <= 1'b0;
         buf_left_reg  <= sample_left_i;
         buf_right_reg <= sample_right_i;
      end else if (frame_start && !buf_empty_reg) begin
         buf_empty_reg <= 1'b1;
      end
   end

   // Underrun pulse and saturating underrun counter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         underrun_reg       <= 1'b0;
         underrun_count_reg <= '0;
      end else begin
         underrun_reg <= frame_start && buf_empty_reg;
         if (frame_start && buf_empty_reg && (underrun_count_reg != 16'hFFFF)) begin
            underrun_count_reg <= underrun_count_reg + 16'd1;
         end
      end
   end

   assign sample_ready_o   = buf_empty_reg;
   assign bclk_o           = bclk_reg;
   assign lrck_o           = lrck_reg;
   assign sdata_o          = sdata_reg;
   assign underrun_o       = underrun_reg;
   assign underrun_count_o = underrun_count_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx. A frame-level reference model
// tracks edges since reset and derives expected pins from the frame layout.
module tb_i2s_tx;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic        mute = 1'b0;
   logic [23:0] left = '0;
   logic [23:0] right = '0;
   logic        ready, bclk, lrck, sdata, under;
   logic [15:0] ucnt;

   int total = 0;
   int bad = 0;

   // Reference model state
   int          k = 0;          // clk edges since reset release
   bit          m_full = 1'b0;  // holding buffer occupied
   bit          m_under = 1'b0;
   bit          m_xfer = 1'b0;  // pair accepted on the last edge
   logic [23:0] m_bl = '0, m_br = '0;   // buffered pair
   logic [23:0] m_fl = '0, m_fr = '0;   // pair being played this frame
   int          m_cnt = 0;

   i2s_tx #(.MCLK_DIV(D)) dut (
      .clk_i            (clk),
      .reset_i          (rst),
      .sample_valid_i   (valid),
      .sample_left_i    (left),
      .sample_right_i   (right),
      .sample_ready_o   (ready),
      .mute_i           (mute),
      .bclk_o           (bclk),
      .lrck_o           (lrck),
      .sdata_o          (sdata),
      .underrun_o       (under),
      .underrun_count_o (ucnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout k=%0d got=running exp=finished", k);
      $fatal(1, "timeout");
   end

   // Bit position within the frame after the current edge
   function automatic int m_bit();
      return ((k / D) + 63) % 64;
   endfunction

   function automatic logic e_sdata();
      int b;
      if (k < D) return 1'b0;
      b = m_bit();
      if (b >= 1 && b <= 24) return m_fl[24 - b];
      if (b >= 33 && b <= 56) return m_fr[56 - b];
      return 1'b0;
   endfunction

   // Expected {bclk, lrck, sdata, ready, underrun, count}
   function automatic logic [20:0] exp_vec();
      logic eb, el;
      eb = ((k % D) >= D / 2);
      el = (k >= D) && (m_bit() >= 32);
      return {eb, el, e_sdata(), ~m_full, m_under, 16'(m_cnt)};
   endfunction

   // Advance one clock: update the model at the edge, return at the falling edge
   task automatic tick();
      bit xfer;
      @(posedge clk);
      m_xfer = 1'b0;
      if (rst) begin
         k = 0; m_full = 1'b0; m_under = 1'b0; m_cnt = 0;
         m_fl = '0; m_fr = '0;
      end else begin
         xfer = valid && !m_full;
         k++;
         m_under = 1'b0;
         if ((k % D == 0) && ((k / D) % 64 == 1)) begin
            if (m_full) begin
               m_fl = mute ? 24'd0 : m_bl;
               m_fr = mute ? 24'd0 : m_br;
               m_full = 1'b0;
            end else begin
               m_fl = '0; m_fr = '0;
               m_under = 1'b1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
         if (xfer) begin
            m_bl = left; m_br = right; m_full = 1'b1; m_xfer = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; mute = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      tick(); tick(); tick();
      total++; if (bclk !== 1'b0)  begin bad++; $display("FAIL reset_bclk got=%b exp=0", bclk); end
      total++; if (lrck !== 1'b0)  begin bad++; $display("FAIL reset_lrck got=%b exp=0", lrck); end
      total++; if (sdata !== 1'b0) begin bad++; $display("FAIL reset_sdata got=%b exp=0", sdata); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
      total++; if (under !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", under); end
      total++; if (ucnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%h exp=0000", ucnt); end
      rst = 1'b0;
      while (k < D + 2) begin
         tick();
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
         if (k == D) begin
            total++;
            if (under !== 1'b1) begin bad++; $display("FAIL first_frame_start k=%0d got=%b exp=1", k, under); end
         end
      end
      $display("test_reset: checks so far %0d", total);
   endtask

   task automatic test_frame();
      logic [23:0] cap_l, cap_r;
      logic        prev_b, prev_l;
      int          last_rise, last_tog, ntog, b;
      do_reset();
      valid = 1'b1; left = 24'hA5A5A5; right = 24'h5A5A5A;
      tick();
      valid = 1'b0;
      cap_l = '0; cap_r = '0; prev_b = bclk; prev_l = lrck;
      last_rise = -1; last_tog = -1; ntog = 0;
      while (k < D + 512 + D) begin
         tick();
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL frame_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
         if (bclk && !prev_b) begin
            if (last_rise >= 0) begin
               total++;
               if (k - last_rise != D) begin bad++; $display("FAIL bclk_period k=%0d got=%0d exp=%0d", k, k - last_rise, D); end
            end
            last_rise = k;
         end
         if (!bclk && prev_b && last_rise >= 0) begin
            total++;
            if (k - last_rise != D / 2) begin bad++; $display("FAIL bclk_duty k=%0d got=%0d exp=%0d", k, k - last_rise, D / 2); end
         end
         if (lrck !== prev_l) begin
            if (last_tog >= 0) begin
               total++;
               if (k - last_tog != 256) begin bad++; $display("FAIL lrck_period k=%0d got=%0d exp=256", k, k - last_tog); end
            end
            last_tog = k; ntog++;
         end
         prev_b = bclk; prev_l = lrck;
         if (k >= D && k < D + 512 && (k % D == D / 2)) begin
            b = m_bit();
            if (b >= 1 && b <= 24) cap_l = {cap_l[22:0], sdata};
            if (b >= 33 && b <= 56) cap_r = {cap_r[22:0], sdata};
         end
      end
      total++; if (cap_l !== 24'hA5A5A5) begin bad++; $display("FAIL frame_left got=%h exp=a5a5a5", cap_l); end
      total++; if (cap_r !== 24'h5A5A5A) begin bad++; $display("FAIL frame_right got=%h exp=5a5a5a", cap_r); end
      total++; if (ntog != 2) begin bad++; $display("FAIL lrck_toggles got=%0d exp=2", ntog); end
      $display("test_frame: left=%h right=%h", cap_l, cap_r);
   endtask

   task automatic test_underrun();
      int pulses;
      do_reset();
      pulses = 0;
      while (k < 2 * 512 + D + 8) begin
         tick();
         if (under === 1'b1) pulses++;
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL underrun_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
      end
      total++; if (ucnt !== 16'd3) begin bad++; $display("FAIL underrun_count got=%0d exp=3", ucnt); end
      total++; if (pulses != 3) begin bad++; $display("FAIL underrun_pulses got=%0d exp=3", pulses); end
      $display("test_underrun: pulses=%0d count=%0d", pulses, ucnt);
   endtask

   task automatic test_stream();
      logic [23:0] base, cap, want;
      logic [23:0] words[$];
      int          b, pulses;
      do_reset();
      base = 24'($urandom);
      valid = 1'b1; left = base; right = 24'($urandom);
      cap = '0; pulses = 0;
      while (k < D + 4 * 512 + D) begin
         tick();
         if (m_xfer) begin left = left + 24'd1; right = right + 24'd1; end
         if (under === 1'b1) pulses++;
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL stream_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
         if (k >= D && (k % D == D / 2)) begin
            b = m_bit();
            if (b >= 1 && b <= 24) cap = {cap[22:0], sdata};
            if (b == 24) words.push_back(cap);
         end
      end
      valid = 1'b0;
      total++; if (words.size() != 4) begin bad++; $display("FAIL stream_frames got=%0d exp=4", words.size()); end
      foreach (words[i]) begin
         want = base + 24'(i);
         total++;
         if (words[i] !== want) begin bad++; $display("FAIL stream_word%0d got=%h exp=%h", i, words[i], want); end
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL stream_underrun got=%0d exp=0", pulses); end
      $display("test_stream: base=%h frames=%0d", base, words.size());
   endtask

   task automatic test_frame_start_xfer();
      logic [23:0] pl, pr, cap_l, cap_r;
      int          ones1, b;
      do_reset();
      while (k < D - 1) tick();
      pl = 24'($urandom) | 24'h800001; pr = 24'($urandom) | 24'h400002;
      valid = 1'b1; left = pl; right = pr;
      tick();
      valid = 1'b0;
      total++; if (under !== 1'b1) begin bad++; $display("FAIL edge_xfer_underrun k=%0d got=%b exp=1", k, under); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL edge_xfer_ready k=%0d got=%b exp=0", k, ready); end
      ones1 = 0; cap_l = '0; cap_r = '0;
      while (k < D + 2 * 512 + D) begin
         tick();
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL edge_xfer_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
         if (k < D + 512 && sdata === 1'b1) ones1++;
         if (k >= D + 512 && k < D + 1024 && (k % D == D / 2)) begin
            b = m_bit();
            if (b >= 1 && b <= 24) cap_l = {cap_l[22:0], sdata};
            if (b >= 33 && b <= 56) cap_r = {cap_r[22:0], sdata};
         end
      end
      total++; if (ones1 != 0) begin bad++; $display("FAIL edge_xfer_frame1 got=%0d exp=0", ones1); end
      total++; if (cap_l !== pl) begin bad++; $display("FAIL edge_xfer_left got=%h exp=%h", cap_l, pl); end
      total++; if (cap_r !== pr) begin bad++; $display("FAIL edge_xfer_right got=%h exp=%h", cap_r, pr); end
      $display("test_frame_start_xfer: left=%h right=%h", cap_l, cap_r);
   endtask

   task automatic test_mute();
      logic prev_r;
      int   rises;
      do_reset();
      mute = 1'b1; valid = 1'b1; left = 24'h7FFFFF; right = 24'h7FFFFF;
      prev_r = ready; rises = 0;
      while (k < 1540) begin
         tick();
         if (ready && !prev_r) rises++;
         prev_r = ready;
         total++;
         if (sdata !== 1'b0) begin bad++; $display("FAIL mute_sdata k=%0d got=%b exp=0", k, sdata); end
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL mute_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
      end
      total++; if (rises != 3) begin bad++; $display("FAIL mute_ready_cycles got=%0d exp=3", rises); end
      valid = 1'b0;
      force dut.underrun_count_reg = 16'hFFFF;
      m_cnt = 65535;
      tick();
      release dut.underrun_count_reg;
      while (k < 2060) begin
         tick();
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL saturate_out k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
         if (k == 2056) begin
            total++;
            if (under !== 1'b1) begin bad++; $display("FAIL saturate_pulse k=%0d got=%b exp=1", k, under); end
         end
      end
      total++; if (ucnt !== 16'hFFFF) begin bad++; $display("FAIL saturate_count got=%h exp=ffff", ucnt); end
      mute = 1'b0;
      $display("test_mute: ready_rises=%0d count=%h", rises, ucnt);
   endtask

   task automatic test_reset_mid();
      do_reset();
      valid = 1'b1; left = 24'($urandom); right = 24'hFFFFFF;
      while (k < 8 * 41 + 5) begin
         tick();
         if (k == 9) valid = 1'b0;
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL midreset_pre k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
      end
      rst = 1'b1;
      #1;
      total++; if (bclk !== 1'b0)  begin bad++; $display("FAIL midreset_bclk got=%b exp=0", bclk); end
      total++; if (lrck !== 1'b0)  begin bad++; $display("FAIL midreset_lrck got=%b exp=0", lrck); end
      total++; if (sdata !== 1'b0) begin bad++; $display("FAIL midreset_sdata got=%b exp=0", sdata); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", ready); end
      total++; if (under !== 1'b0) begin bad++; $display("FAIL midreset_underrun got=%b exp=0", under); end
      tick();
      tick();
      total++; if (under !== 1'b0) begin bad++; $display("FAIL midreset_hold_underrun got=%b exp=0", under); end
      rst = 1'b0;
      while (k < D + 2) begin
         tick();
         total++;
         if ({bclk, lrck, sdata, ready, under, ucnt} !== exp_vec()) begin
            bad++;
            $display("FAIL midreset_restart k=%0d got=%h exp=%h", k, {bclk, lrck, sdata, ready, under, ucnt}, exp_vec());
         end
      end
      total++; if (ucnt !== 16'd1) begin bad++; $display("FAIL midreset_count got=%0d exp=1", ucnt); end
      $display("test_reset_mid: restart count=%0d", ucnt);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_underrun();
      test_stream();
      test_frame_start_xfer();
      test_mute();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
